// File: rtl/rgb_arb_pkg.sv
// Shared definitions for the RGB status arbiter: state codes, level width,
// captured-level record and the fixed-priority pick helper.
package rgb_arb_pkg;

    localparam int LVL_W   = 8;
    localparam int MAX_REQ = 32;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SHOW = 1'b1;

    typedef struct packed {
        logic [LVL_W-1:0] r;
        logic [LVL_W-1:0] g;
        logic [LVL_W-1:0] b;
    } rgb_lvl_t;

    // Isolates the lowest set bit: index 0 is the highest priority.
    function automatic logic [MAX_REQ-1:0] prio_onehot(input logic [MAX_REQ-1:0] vec);
        return vec & (~vec + MAX_REQ'(1));
    endfunction

endpackage

// File: rtl/rgb_status_arbiter_ms_tick_gen.sv
// Millisecond tick-enable generator: one-cycle pulse every CLK_HZ/1000 cycles.
module ms_tick_gen #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic ms_tick
);

    localparam int              DIV = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
    localparam int              CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   TC  = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign ms_tick = (cnt == TC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (ms_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/rgb_status_arbiter.sv
// Fixed-priority owner of the shared RGB LED with minimum dwell, optional blink
// and an 8-bit PWM drive.
//   state   | meaning
//   ST_IDLE | no owner, LED dark, grant all-zero
//   ST_SHOW | grant_q owns the LED, levels tracked live from its slice
module rgb_status_arbiter
    import rgb_arb_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int N_REQ    = 3,
    parameter int DWELL_MS = 500,
    parameter int BLINK_MS = 250
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       blink,
    input  logic [LVL_W*N_REQ-1:0] r_lvl,
    input  logic [LVL_W*N_REQ-1:0] g_lvl,
    input  logic [LVL_W*N_REQ-1:0] b_lvl,
    output logic [N_REQ-1:0]       grant,
    output logic                   busy,
    output logic                   rgb_r,
    output logic                   rgb_g,
    output logic                   rgb_b
);

    localparam int            BLINK_EFF = (BLINK_MS < 1) ? 1 : BLINK_MS;
    localparam int            BW        = (BLINK_EFF > 1) ? $clog2(BLINK_EFF) : 1;
    localparam int            DW        = (DWELL_MS > 0) ? $clog2(DWELL_MS + 1) : 1;
    localparam logic [BW-1:0] BLINK_TC  = BW'(BLINK_EFF - 1);
    localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_MS);

    logic                 ms_tick;
    logic [0:0]           state_q, state_d;
    logic [N_REQ-1:0]     grant_q, grant_d;
    logic                 new_grant;
    logic [MAX_REQ-1:0]   pend_oh_w;
    logic [N_REQ-1:0]     pend_oh;
    logic                 unused_pend_hi;
    logic                 owner_live;
    logic [N_REQ-1:0]     higher;
    logic [DW-1:0]        dwell_cnt;
    logic                 dwell_done;
    logic [BW-1:0]        blink_cnt;
    logic                 blink_on;
    logic                 blink_q;
    rgb_lvl_t             lvl_q, sel_lvl;
    logic                 sel_blink;
    logic [LVL_W-1:0]     pwm_cnt;

    ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_ms_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .ms_tick (ms_tick)
    );

    assign pend_oh_w      = prio_onehot(MAX_REQ'(req));
    assign pend_oh        = pend_oh_w[N_REQ-1:0];
    assign unused_pend_hi = ^pend_oh_w[MAX_REQ-1:N_REQ];
    assign owner_live     = |(req & grant_q);
    // grant_q is one-hot in SHOW, so grant_q-1 masks every higher-priority index.
    assign higher         = req & (grant_q - N_REQ'(1));
    assign dwell_done     = (dwell_cnt == DWELL_MAX);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        new_grant = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d   = ST_SHOW;
                    grant_d   = pend_oh;
                    new_grant = 1'b1;
                end
            end
            default: begin
                if (!owner_live) begin
                    if (|req) begin
                        grant_d   = pend_oh;
                        new_grant = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                    end
                end else if (|higher && dwell_done) begin
                    grant_d   = pend_oh;
                    new_grant = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        sel_lvl   = '0;
        sel_blink = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                sel_lvl.r = r_lvl[i*LVL_W +: LVL_W];
                sel_lvl.g = g_lvl[i*LVL_W +: LVL_W];
                sel_lvl.b = b_lvl[i*LVL_W +: LVL_W];
                sel_blink = blink[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            dwell_cnt <= '0;
            pwm_cnt   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            pwm_cnt <= pwm_cnt + LVL_W'(1);
            if (new_grant) begin
                dwell_cnt <= '0;
            end else if (state_q == ST_SHOW && ms_tick && !dwell_done) begin
                dwell_cnt <= dwell_cnt + DW'(1);
            end
        end
    end

    // Blink half-period is a reloading down-counter; phase restarts on every new grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (new_grant || state_q != ST_SHOW || !blink_q) begin
            blink_cnt <= BLINK_TC;
            blink_on  <= 1'b1;
        end else if (ms_tick) begin
            if (blink_cnt == '0) begin
                blink_cnt <= BLINK_TC;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt - BW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q   <= '0;
            blink_q <= 1'b0;
        end else if (state_q == ST_SHOW) begin
            lvl_q   <= sel_lvl;
            blink_q <= sel_blink;
        end else begin
            lvl_q   <= '0;
            blink_q <= 1'b0;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q == ST_SHOW);
    assign rgb_r = busy & blink_on & (pwm_cnt < lvl_q.r);
    assign rgb_g = busy & blink_on & (pwm_cnt < lvl_q.g);
    assign rgb_b = busy & blink_on & (pwm_cnt < lvl_q.b);

    grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));

endmodule

// File: tb/tb_rgb_status_arbiter.sv
// Scoreboard bench: a cycle-level reference model pushes expected outputs, a
// negedge monitor pops and compares; directed scenarios then random traffic.
module tb_rgb_status_arbiter;

    localparam int N      = 3;
    localparam int CLK_HZ = 10_000;
    localparam int DWELL  = 4;
    localparam int BLINK  = 2;
    localparam int MS_DIV = CLK_HZ / 1000;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b1;
    logic [N-1:0]   req   = '0;
    logic [N-1:0]   blink = '0;
    logic [7:0]     lr [N];
    logic [7:0]     lg [N];
    logic [7:0]     lb [N];
    logic [8*N-1:0] r_lvl, g_lvl, b_lvl;
    logic [N-1:0]   grant;
    logic           busy, rgb_r, rgb_g, rgb_b;

    int n_vec = 0;
    int n_bad = 0;
    int exp_q[$];

    assign r_lvl = {lr[2], lr[1], lr[0]};
    assign g_lvl = {lg[2], lg[1], lg[0]};
    assign b_lvl = {lb[2], lb[1], lb[0]};

    rgb_status_arbiter #(
        .CLK_HZ(CLK_HZ), .N_REQ(N), .DWELL_MS(DWELL), .BLINK_MS(BLINK)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .blink(blink),
        .r_lvl(r_lvl), .g_lvl(g_lvl), .b_lvl(b_lvl),
        .grant(grant), .busy(busy), .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Reference model: owner index (-1 = nobody), ms ticks since grant,
    // ms ticks spent blinking, and the levels latched from the previous owner.
    int m_owner, m_dwell, m_bt, m_cyc, m_pwm, m_r, m_g, m_b;
    bit m_bq, m_on;

    task automatic m_reset();
        m_owner = -1; m_dwell = 0; m_bt = 0; m_cyc = 0; m_pwm = 0;
        m_r = 0; m_g = 0; m_b = 0; m_bq = 0; m_on = 1;
    endtask

    task automatic m_step();
        int  p, nown, nr, ng_, nb;
        bit  ng, tick, nbq;
        tick = (m_cyc % MS_DIV) == MS_DIV - 1;
        m_cyc++;
        p    = lowest(req);
        nown = m_owner;
        ng   = 0;
        if (m_owner < 0) begin
            if (p >= 0) begin nown = p; ng = 1; end
        end else if (!req[m_owner]) begin
            nown = p; ng = (p >= 0);
        end else if (p >= 0 && p < m_owner && m_dwell >= DWELL) begin
            nown = p; ng = 1;
        end
        if (m_owner >= 0) begin
            nr = lr[m_owner]; ng_ = lg[m_owner]; nb = lb[m_owner]; nbq = blink[m_owner];
        end else begin
            nr = 0; ng_ = 0; nb = 0; nbq = 0;
        end
        if (ng) begin
            m_dwell = 0; m_bt = 0;
        end else begin
            if (m_owner >= 0 && tick && m_dwell < DWELL) m_dwell++;
            if (m_owner >= 0 && m_bq) begin
                if (tick) m_bt++;
            end else begin
                m_bt = 0;
            end
        end
        m_on    = ((m_bt / BLINK) % 2) == 0;
        m_owner = nown;
        m_r = nr; m_g = ng_; m_b = nb; m_bq = nbq;
        m_pwm = (m_pwm + 1) % 256;
    endtask

    function automatic int m_outputs();
        int g, bz, r, gg, b;
        bz = (m_owner >= 0) ? 1 : 0;
        g  = (m_owner >= 0) ? (1 << m_owner) : 0;
        r  = (bz == 1 && m_on && m_pwm < m_r) ? 1 : 0;
        gg = (bz == 1 && m_on && m_pwm < m_g) ? 1 : 0;
        b  = (bz == 1 && m_on && m_pwm < m_b) ? 1 : 0;
        return (g << 4) | (bz << 3) | (r << 2) | (gg << 1) | b;
    endfunction

    initial begin
        m_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) m_reset();
            else m_step();
            exp_q.push_back(m_outputs());
        end
    end

    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("outputs{grant,busy,r,g,b}", int'({grant, busy, rgb_r, rgb_g, rgb_b}), e);
            end
        end
    end

    initial begin
        int cnt_g, cnt_r;
        for (int i = 0; i < N; i++) begin lr[i] = 0; lg[i] = 0; lb[i] = 0; end
        #1 rst_n = 1'b0;
        #2 check("reset_outputs", int'({grant, busy, rgb_r, rgb_g, rgb_b}), 0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        // Source 1 at half green
        @(negedge clk); lg[1] = 8'd128; req = 3'b010;
        @(negedge clk); check("first_grant", int'(grant), 3'b010);
        repeat (2) @(negedge clk);
        cnt_g = 0; cnt_r = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            cnt_g += int'(rgb_g);
            cnt_r += int'(rgb_r) + int'(rgb_b);
        end
        check("green_duty", cnt_g, 128);
        check("red_blue_dark", cnt_r, 0);

        // Owner 1 drops, 2 takes over; 0 arrives at ~1 ms dwell
        lr[2] = 8'd60; lb[2] = 8'd200; lr[0] = 8'd10; lg[0] = 8'd250;
        req = 3'b100;
        repeat (10) @(negedge clk);
        req = 3'b101;
        repeat (20) @(negedge clk);
        check("no_preempt_before_dwell", int'(grant), 3'b100);
        repeat (40) @(negedge clk);
        check("preempt_after_dwell", int'(grant), 3'b001);

        // Lower-priority pending is ignored, owner drop hands over
        repeat (20) @(negedge clk);
        req = 3'b100;
        @(negedge clk); check("handover_on_drop", int'(grant), 3'b100);
        repeat (20) @(negedge clk);

        // Blinking full red on source 1
        lr[1] = 8'd255; lg[1] = 8'd0; blink[1] = 1'b1; req = 3'b010;
        repeat (120) @(negedge clk);
        blink[1] = 1'b0;

        // Simultaneous drop and rise
        req = 3'b001;
        repeat (10) @(negedge clk);
        req = 3'b110;
        @(negedge clk); check("drop_and_rise", int'(grant), 3'b010);
        repeat (15) @(negedge clk);
        req = 3'b000;
        repeat (2) @(negedge clk);
        check("idle_outputs", int'({grant, busy, rgb_r, rgb_g, rgb_b}), 0);

        // Asynchronous reset mid-SHOW
        req = 3'b010;
        repeat (20) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check("async_reset", int'({grant, busy, rgb_r, rgb_g, rgb_b}), 0);
        @(negedge clk); #1 rst_n = 1'b1;
        @(negedge clk); check("regrant_after_reset", int'(grant), 3'b010);
        repeat (5) @(negedge clk);

        // Random traffic
        for (int s = 0; s < 80; s++) begin
            for (int i = 0; i < N; i++) begin
                lr[i] = 8'($urandom); lg[i] = 8'($urandom); lb[i] = 8'($urandom);
            end
            blink = N'($urandom);
            req   = N'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                #1 rst_n = 1'b0;
                @(negedge clk); #1 rst_n = 1'b1;
            end
            repeat ($urandom_range(1, 60)) @(negedge clk);
        end

        req = '0;
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
